jtag_ir_dr_path: RTL and testbench
==================================

// Module: jtag_ir_dr_path
// PURPOSE
//   JTAG instruction/data-register path directly downstream of the TAP controller.
//   Consumes the TAP capture/shift/update qualifiers and holds the instruction register.
//   Decodes the instruction, owns the BYPASS and IDCODE data registers, and steers the
//   external boundary-scan chain. Muxes and retimes the serial TDO.
// PARAMETERS
//   IR_W        4             instruction register width (>=2)
//   IDCODE_VAL  32'h1234_5677 value captured into IDCODE DR; bit0 must be 1
// PORTS
//   TCK           in   1     test clock; only clock in the block
//   TRST          in   1     asynchronous, active-high reset
//   tlr           in   1     TAP is in Test-Logic-Reset (synchronous reset of IR)
//   tdi           in   1     serial test data in
//   select        in   1     1 = IR path drives TDO, 0 = DR path
//   capture_ir    in   1     capture enable, IR
//   shift_ir      in   1     shift enable, IR
//   update_ir     in   1     update enable, IR
//   capture_dr    in   1     capture enable, selected DR
//   shift_dr      in   1     shift enable, selected DR
//   update_dr     in   1     update enable, selected DR
//   bsr_tdo       in   1     serial out of external boundary-scan chain
//   bsr_tdi       out  1     serial in to boundary-scan chain (= tdi)
//   bsr_capture   out  1     capture_dr & sel_bsr
//   bsr_shift     out  1     shift_dr & sel_bsr
//   bsr_update    out  1     update_dr & sel_bsr
//   bs_mode       out  1     1 while instruction = EXTEST (pins driven from BSR)
//   ir_q          out  IR_W  current (updated) instruction
//   tdo           out  1     serial test data out
//   tdo_en        out  1     TDO output enable
// BEHAVIOUR
// - All state on rising TCK, except tdo/tdo_en, which update on falling TCK.
//   TRST resets everything asynchronously.
// - Reset values:
//   - ir_q = OP_IDCODE, ir_sr = 0, bypass_ff = 0, id_sr = IDCODE_VAL.
//   - tdo = 0, tdo_en = 0, bs_mode = 0.
// - tlr = 1 at a rising edge: ir_q <= OP_IDCODE. Shift registers are untouched.
// - IR shift register ir_sr, per rising edge, priority capture > shift > update:
//   - capture_ir: ir_sr <= {0.., 2'b01}.
//   - shift_ir: ir_sr <= {tdi, ir_sr[IR_W-1:1]}, i.e. LSB out first.
//   - update_ir: ir_q <= ir_sr. Only this changes decode; mid-shift ir_sr never affects it.
// - Decode of ir_q:
//   - EXTEST -> sel_bsr = 1, bs_mode = 1.
//   - SAMPLE -> sel_bsr = 1.
//   - IDCODE -> sel_id.
//   - BYPASS or any unlisted opcode -> sel_byp.
// - DR ops act only on the selected DR; unselected DRs hold.
//   - bypass_ff: capture_dr -> 0; shift_dr -> tdi.
//   - id_sr: capture_dr -> IDCODE_VAL; shift_dr -> {tdi, id_sr[31:1]}.
//   - BSR: strobes gated combinationally, zero latency.
// - TDO, on falling TCK:
//   - tdo_en <= shift_ir | shift_dr.
//   - tdo <= select ? ir_sr[0] : (sel_bsr ? bsr_tdo : sel_id ? id_sr[0] : bypass_ff).
//   - When tdo_en = 0, tdo holds its last value.
// - Latency: bit n shifted in at rising edge k appears at tdo on the falling edge
//   after rising edge k+W-1, where W is the path length (1 for bypass).
// - Simultaneous IR and DR enables (illegal from the TAP): both act independently;
//   select alone decides TDO.
// - TRST mid-shift: partial shift discarded, ir_q = OP_IDCODE on release.
// STRUCTURE
// - Shared package jtag_pkg: OP_EXTEST = 'h0, OP_SAMPLE = 'h1, OP_IDCODE = 'h2,
//   OP_BYPASS = all-ones (sized to IR_W), and IR_CAPTURE_PAT = 2'b01.
// - One sub-module, jtag_shift_reg #(W, RST_VAL): async reset, capture/shift,
//   capture value, serial out. Instantiated for ir_sr and id_sr.
// - bypass_ff, decode, strobe gating and the TDO mux stay inline.
// TESTING
// 1. Release TRST, capture_dr, 32x shift_dr -> tdo yields 0x12345677 LSB-first.
//    tdo_en = 1 only during the shifts.
// 2. capture_ir, shift 4b'1111, update_ir -> ir_q = 'hF.
//    A DR shift of 0b1011 then returns a 0 followed by 1,1,0,1 (one-bit delay).
// 3. capture_ir, then shift -> the first two tdo bits are 1,0.
//    Load 'h0 -> bs_mode = 1; bsr_shift follows shift_dr; tdo follows bsr_tdo.
// 4. Load illegal opcode 'h7 -> behaves as BYPASS, bs_mode = 0, bsr_* strobes = 0.
// 5. Load 'h0, then tlr for one cycle -> ir_q = 'h2 and bs_mode = 0 on the next edge.
// 6. Assert TRST mid-IR-shift with no update -> all outputs at reset values immediately.
//    ir_q = 'h2 after release.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared opcodes, capture pattern and DR-select type for the JTAG IR/DR path.
package jtag_pkg;

  // Opcodes are zero-extended to the instruction register width at the use site.
  localparam int unsigned OP_EXTEST = 'h0;
  localparam int unsigned OP_SAMPLE = 'h1;
  localparam int unsigned OP_IDCODE = 'h2;

  // Fixed low bits loaded into the IR shift register on capture.
  localparam logic [1:0] IR_CAPTURE_PAT = 2'b01;

  // Which data register sits between TDI and TDO.
  typedef enum logic [1:0] {
    DrBypass,
    DrIdcode,
    DrBsr
  } dr_sel_e;

  // BYPASS is all ones at whatever width the IR has.
  function automatic logic [31:0] op_bypass(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/jtag_ir_dr_path_if.sv
// TAP-side qualifiers, boundary-scan chain hookup and serial/decoded outputs.
interface jtag_ir_dr_path_if #(
  parameter int unsigned IR_W = 4
);
  logic            tlr;
  logic            tdi;
  logic            select;
  logic            capture_ir;
  logic            shift_ir;
  logic            update_ir;
  logic            capture_dr;
  logic            shift_dr;
  logic            update_dr;
  logic            bsr_tdo;
  logic            bsr_tdi;
  logic            bsr_capture;
  logic            bsr_shift;
  logic            bsr_update;
  logic            bs_mode;
  logic [IR_W-1:0] ir_q;
  logic            tdo;
  logic            tdo_en;

  // Driven by the TAP controller / test environment.
  modport master (
    output tlr, tdi, select, capture_ir, shift_ir, update_ir,
    output capture_dr, shift_dr, update_dr, bsr_tdo,
    input  bsr_tdi, bsr_capture, bsr_shift, bsr_update, bs_mode, ir_q, tdo, tdo_en
  );

  // The IR/DR path itself.
  modport slave (
    input  tlr, tdi, select, capture_ir, shift_ir, update_ir,
    input  capture_dr, shift_dr, update_dr, bsr_tdo,
    output bsr_tdi, bsr_capture, bsr_shift, bsr_update, bs_mode, ir_q, tdo, tdo_en
  );

endinterface

// File: rtl/jtag_shift_reg.sv
// Generic capture/shift register, LSB shifted out first, MSB fed from serial in.
module jtag_shift_reg #(
  parameter int unsigned   W       = 4,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         capture_i,
  input  logic         shift_i,
  input  logic [W-1:0] cap_val_i,
  input  logic         sdi_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q, sr_d;

  // Next state: capture wins over shift, otherwise hold.
  always_comb begin
    sr_d = sr_q;
    if (capture_i) begin
      sr_d = cap_val_i;
    end else if (shift_i) begin
      sr_d = {sdi_i, sr_q[W-1:1]};
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= RST_VAL;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q;

endmodule

// File: rtl/jtag_ir_dr_path.sv
// JTAG instruction register, decode, BYPASS/IDCODE DRs, BSR strobe gating and TDO retiming.
module jtag_ir_dr_path
  import jtag_pkg::*;
#(
  parameter int unsigned IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5677
) (
  input logic               TCK,
  input logic               TRST,
  jtag_ir_dr_path_if.slave  bus
);

  localparam logic [IR_W-1:0] OpExtest = IR_W'(OP_EXTEST);
  localparam logic [IR_W-1:0] OpSample = IR_W'(OP_SAMPLE);
  localparam logic [IR_W-1:0] OpIdcode = IR_W'(OP_IDCODE);
  localparam logic [IR_W-1:0] OpBypass = IR_W'(op_bypass(IR_W));
  localparam logic [IR_W-1:0] IrCapVal = IR_W'(IR_CAPTURE_PAT);

  logic [IR_W-1:0] ir_sr_q;
  logic [IR_W-1:0] ir_q_q, ir_q_d;
  logic [31:0]     id_sr_q;
  logic            bypass_q, bypass_d;
  logic            tdo_q, tdo_d;
  logic            tdo_en_q, tdo_en_d;
  dr_sel_e         dr_sel;
  logic            sel_bsr, sel_id, sel_byp;
  logic            unused_id_hi;

  // IR shift register: capture pattern, shift LSB-first.
  jtag_shift_reg #(
    .W       (IR_W),
    .RST_VAL ('0)
  ) u_ir_sr (
    .clk_i     (TCK),
    .rst_i     (TRST),
    .capture_i (bus.capture_ir),
    .shift_i   (bus.shift_ir),
    .cap_val_i (IrCapVal),
    .sdi_i     (bus.tdi),
    .q_o       (ir_sr_q)
  );

  // IDCODE DR, only active while IDCODE is the current instruction.
  jtag_shift_reg #(
    .W       (32),
    .RST_VAL (IDCODE_VAL)
  ) u_id_sr (
    .clk_i     (TCK),
    .rst_i     (TRST),
    .capture_i (bus.capture_dr & sel_id),
    .shift_i   (bus.shift_dr & sel_id),
    .cap_val_i (IDCODE_VAL),
    .sdi_i     (bus.tdi),
    .q_o       (id_sr_q)
  );

  // Only bit 0 of IDCODE feeds TDO; the rest lives inside the shift register.
  assign unused_id_hi = ^id_sr_q[31:1];

  // Instruction decode from the updated IR only; unknown opcodes fall back to BYPASS.
  always_comb begin
    case (ir_q_q)
      OpExtest, OpSample: dr_sel = DrBsr;
      OpIdcode:           dr_sel = DrIdcode;
      OpBypass:           dr_sel = DrBypass;
      default:            dr_sel = DrBypass;
    endcase
  end

  assign sel_bsr = (dr_sel == DrBsr);
  assign sel_id  = (dr_sel == DrIdcode);
  assign sel_byp = (dr_sel == DrBypass);

  // Instruction update; TLR forces IDCODE, update loses to capture/shift in the same cycle.
  always_comb begin
    ir_q_d = ir_q_q;
    if (bus.tlr) begin
      ir_q_d = OpIdcode;
    end else if (bus.update_ir && !bus.capture_ir && !bus.shift_ir) begin
      ir_q_d = ir_sr_q;
    end
  end

  // Updated instruction register.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_q_q <= OpIdcode;
    end else begin
      ir_q_q <= ir_q_d;
    end
  end

  // BYPASS DR next state: capture clears, shift loads TDI.
  always_comb begin
    bypass_d = bypass_q;
    if (sel_byp && bus.capture_dr) begin
      bypass_d = 1'b0;
    end else if (sel_byp && bus.shift_dr) begin
      bypass_d = bus.tdi;
    end
  end

  // BYPASS DR register.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      bypass_q <= 1'b0;
    end else begin
      bypass_q <= bypass_d;
    end
  end

  // TDO source select; tdo holds whenever no shift is in progress.
  always_comb begin
    tdo_en_d = bus.shift_ir | bus.shift_dr;
    tdo_d    = tdo_q;
    if (tdo_en_d) begin
      if (bus.select) begin
        tdo_d = ir_sr_q[0];
      end else if (sel_bsr) begin
        tdo_d = bus.bsr_tdo;
      end else if (sel_id) begin
        tdo_d = id_sr_q[0];
      end else begin
        tdo_d = bypass_q;
      end
    end
  end

  // TDO is retimed on the falling edge so it is stable for the next rising edge.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign bus.bsr_tdi     = bus.tdi;
  assign bus.bsr_capture = bus.capture_dr & sel_bsr;
  assign bus.bsr_shift   = bus.shift_dr & sel_bsr;
  assign bus.bsr_update  = bus.update_dr & sel_bsr;
  assign bus.bs_mode     = (ir_q_q == OpExtest);
  assign bus.ir_q        = ir_q_q;
  assign bus.tdo         = tdo_q;
  assign bus.tdo_en      = tdo_en_q;

endmodule

// File: tb/tb_jtag_ir_dr_path.sv
// Directed bench for jtag_ir_dr_path with a TDO scoreboard queue.
module tb_jtag_ir_dr_path;

  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_CIR  = 6'b100000;
  localparam logic [5:0] E_SIR  = 6'b010000;
  localparam logic [5:0] E_UIR  = 6'b001000;
  localparam logic [5:0] E_CDR  = 6'b000100;
  localparam logic [5:0] E_SDR  = 6'b000010;
  localparam logic [5:0] E_UDR  = 6'b000001;

  logic       TCK  = 1'b0;
  logic       TRST = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic       exp_q[$];
  logic [3:0] exp_ir = 4'h2;
  logic       exp_bsr;
  logic [31:0] idv = 32'h1234_5677;

  jtag_ir_dr_path_if #(.IR_W(4)) bus ();

  jtag_ir_dr_path #(
    .IR_W       (4),
    .IDCODE_VAL (32'h1234_5677)
  ) dut (
    .TCK  (TCK),
    .TRST (TRST),
    .bus  (bus)
  );

  always #5 TCK = ~TCK;

  assign exp_bsr = (exp_ir == 4'h0) || (exp_ir == 4'h1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One TCK cycle: drive at rise+1, check at fall+1, return at next rise+1.
  task automatic cyc(input logic [5:0] en, input logic din, input logic bt,
                     input logic do_chk, input logic expv);
    logic e;
    {bus.capture_ir, bus.shift_ir, bus.update_ir} = en[5:3];
    {bus.capture_dr, bus.shift_dr, bus.update_dr} = en[2:0];
    bus.tdi     = din;
    bus.bsr_tdo = bt;
    if (do_chk) exp_q.push_back(expv);
    @(negedge TCK);
    #1;
    chk("tdo_en", {31'd0, bus.tdo_en}, {31'd0, en[4] | en[1]});
    chk("bsr_strobes", {29'd0, bus.bsr_capture, bus.bsr_shift, bus.bsr_update},
        {29'd0, en[2] & exp_bsr, en[1] & exp_bsr, en[0] & exp_bsr});
    chk("bsr_tdi", {31'd0, bus.bsr_tdi}, {31'd0, din});
    if (do_chk) begin
      e = exp_q.pop_front();
      chk("tdo", {31'd0, bus.tdo}, {31'd0, e});
    end
    @(posedge TCK);
    #1;
  endtask

  // Capture IR (expect 1,0,0,0 on TDO), shift in op LSB-first, update.
  task automatic load_ir(input logic [3:0] op);
    bus.select = 1'b1;
    cyc(E_CIR, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(E_SIR, op[0], 1'b0, 1'b1, 1'b1);
    cyc(E_SIR, op[1], 1'b0, 1'b1, 1'b0);
    cyc(E_SIR, op[2], 1'b0, 1'b1, 1'b0);
    cyc(E_SIR, op[3], 1'b0, 1'b1, 1'b0);
    cyc(E_UIR, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_ir = op;
    chk("ir_q_load", {28'd0, bus.ir_q}, {28'd0, op});
    chk("bs_mode_load", {31'd0, bus.bs_mode}, {31'd0, op == 4'h0});
    bus.select = 1'b0;
  endtask

  initial begin
    bus.tlr = 1'b0; bus.tdi = 1'b0; bus.select = 1'b0; bus.bsr_tdo = 1'b0;
    bus.capture_ir = 1'b0; bus.shift_ir = 1'b0; bus.update_ir = 1'b0;
    bus.capture_dr = 1'b0; bus.shift_dr = 1'b0; bus.update_dr = 1'b0;

    // Reset values
    #1 TRST = 1'b1;
    #1;
    chk("rst_ir_q", {28'd0, bus.ir_q}, 32'h2);
    chk("rst_tdo", {31'd0, bus.tdo}, 32'h0);
    chk("rst_tdo_en", {31'd0, bus.tdo_en}, 32'h0);
    chk("rst_bs_mode", {31'd0, bus.bs_mode}, 32'h0);
    @(posedge TCK);
    #1 TRST = 1'b0;

    // 1: IDCODE read-out LSB-first
    cyc(E_CDR, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) cyc(E_SDR, 1'b0, 1'b0, 1'b1, idv[i]);
    cyc(E_NONE, 1'b0, 1'b0, 1'b1, idv[31]);

    // 2: load BYPASS, one-bit delay through bypass_ff
    load_ir(4'hF);
    cyc(E_CDR, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(E_SDR, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(E_SDR, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(E_SDR, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(E_SDR, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(E_SDR, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(E_NONE, 1'b0, 1'b0, 1'b1, 1'b1);

    // 3: EXTEST, BSR strobes and bsr_tdo on TDO
    load_ir(4'h0);
    cyc(E_CDR, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(E_SDR, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(E_SDR, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(E_SDR, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(E_SDR, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(E_UDR, 1'b0, 1'b0, 1'b0, 1'b0);

    // 4: illegal opcode behaves as BYPASS, BSR idle
    load_ir(4'h7);
    cyc(E_CDR, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(E_SDR, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(E_SDR, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(E_SDR, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(E_UDR, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: TLR forces IDCODE
    load_ir(4'h0);
    bus.tlr = 1'b1;
    cyc(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.tlr = 1'b0;
    exp_ir = 4'h2;
    chk("tlr_ir_q", {28'd0, bus.ir_q}, 32'h2);
    chk("tlr_bs_mode", {31'd0, bus.bs_mode}, 32'h0);

    // 6: TRST in the middle of an IR shift
    load_ir(4'h0);
    bus.select = 1'b1;
    cyc(E_CIR, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(E_SIR, 1'b1, 1'b0, 1'b1, 1'b1);
    bus.shift_ir = 1'b1;
    #2 TRST = 1'b1;
    exp_ir = 4'h2;
    #1;
    chk("trst_tdo", {31'd0, bus.tdo}, 32'h0);
    chk("trst_tdo_en", {31'd0, bus.tdo_en}, 32'h0);
    chk("trst_ir_q", {28'd0, bus.ir_q}, 32'h2);
    chk("trst_bs_mode", {31'd0, bus.bs_mode}, 32'h0);
    bus.shift_ir = 1'b0;
    @(posedge TCK);
    #1 TRST = 1'b0;
    chk("trst_rel_ir_q", {28'd0, bus.ir_q}, 32'h2);
    // Partial shift discarded: updating now loads the reset IR shift value.
    cyc(E_UIR, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_ir = 4'h0;
    chk("trst_sr_cleared", {28'd0, bus.ir_q}, 32'h0);
    cyc(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
